// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: serializes core ROM-port fetches onto a req/addr_ok/data_ok bus.
// Define IFB_HIT_BUF_EN to build a one-entry hit buffer that serves repeated fetches with no stall.
module inst_fetch_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_data_o,
    output logic        stall_req_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_addr_ok_i,
    input  logic        mem_data_ok_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nxt;
    logic [31:2] req_addr;
    logic [31:0] rdata;
    logic [31:0] buf_data;
    logic kill, hit, busy, done_ok, idle_like, miss, data_ok;
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, cpu_addr_i[1:0]};
    assign busy = state == REQ || state == WAIT;
    assign data_ok = state == WAIT && mem_data_ok_i;
    assign done_ok = state == DONE && cpu_ce_i && cpu_addr_i[31:2] == req_addr;
    assign idle_like = state == IDLE || (state == DONE && !done_ok);
    assign miss = idle_like && cpu_ce_i && !hit;

`ifdef IFB_HIT_BUF_EN
    logic        buf_valid;
    logic [31:2] buf_tag;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (data_ok && !kill && cpu_ce_i) begin
            buf_valid <= 1'b1;
            buf_tag   <= req_addr;
            buf_data  <= mem_rdata_i;
        end
    assign hit = cpu_ce_i && buf_valid && buf_tag == cpu_addr_i[31:2];
`else
    assign buf_data = '0;
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state == REQ  ? (mem_addr_ok_i ? WAIT : REQ) :
                    state == WAIT ? (mem_data_ok_i ? ((kill || !cpu_ce_i) ? IDLE : DONE) : WAIT) :
                    miss          ? REQ : IDLE;
    end

    // a dropped ce during an outstanding fetch is remembered until the bus returns the word
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            kill     <= 1'b0;
            req_addr <= '0;
            rdata    <= '0;
        end else begin
            kill     <= data_ok ? 1'b0 : (kill || (busy && !cpu_ce_i));
            req_addr <= miss ? cpu_addr_i[31:2] : req_addr;
            rdata    <= data_ok ? mem_rdata_i : rdata;
        end

    always_comb begin
        mem_req_o   = state == REQ;
        mem_addr_o  = {req_addr, 2'b00};
        stall_req_o = !rst && (miss || (busy && cpu_ce_i));
        cpu_data_o  = rst ? 32'h0 : done_ok ? rdata : (idle_like && hit) ? buf_data : 32'h0;
    end
endmodule
